// File: rtl/core_pixbuf.sv
// 192-byte dual-ported pixel buffer: 32-bit byte-scattered writes in FILL, 24-bit RGB gathers in DRAIN.
// Optional sticky overflow/underflow reporting on O_ERR is built when CORE_PIXBUF_ERR_EN is defined.
module core_pixbuf #(
    parameter int DEPTH  = 192,
    parameter int WORDS  = 48,
    parameter int PIXELS = 64
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic        I_CLEAR,
    input  logic        I_WR_EN,
    input  logic [7:0]  I_WR_ADDR0,
    input  logic [7:0]  I_WR_ADDR1,
    input  logic [7:0]  I_WR_ADDR2,
    input  logic [7:0]  I_WR_ADDR3,
    input  logic [31:0] I_WR_DATA,
    output logic        O_WR_READY,
    input  logic        I_RD_EN,
    input  logic [7:0]  I_RD_ADDRR,
    input  logic [7:0]  I_RD_ADDRG,
    input  logic [7:0]  I_RD_ADDRB,
    output logic [23:0] O_RD_DATA,
    output logic        O_RD_VALID,
    output logic        O_FULL,
    output logic        O_EMPTY,
    output logic [5:0]  O_WORD_COUNT,
    output logic [5:0]  O_PIXEL_COUNT,
    output logic [1:0]  O_ERR
);

    // Handshake: a write is taken on any edge where I_WR_EN=1 and O_WR_READY=1 (FILL);
    // a read is taken where I_RD_EN=1 in DRAIN and answered by O_RD_VALID one cycle later.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] DEPTH_B    = 8'(DEPTH);
    localparam logic [5:0] LAST_WORD  = 6'(WORDS - 1);
    localparam logic [5:0] LAST_PIXEL = 6'(PIXELS - 1);

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [5:0]  word_count;
    logic [5:0]  pixel_count;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        wr_accept;
    logic        rd_accept;
    logic        ctrl_idle;

    assign wr_accept = I_WR_EN && (state == FILL);
    assign rd_accept = I_RD_EN && (state == DRAIN);
    assign ctrl_idle = !I_HRESET && !I_CLEAR;

    // Out-of-range component addresses read as zero rather than aliasing into the array.
    function automatic logic [7:0] rd_byte(input logic [7:0] addr);
        logic [7:0] value;
        value = 8'h00;
        if (addr < DEPTH_B) begin
            value = mem[addr];
        end
        return value;
    endfunction

    // Storage carries no reset; each byte lane is dropped independently when out of range.
    always_ff @(posedge I_HCLK) begin
        if (wr_accept && ctrl_idle) begin
            if (I_WR_ADDR0 < DEPTH_B) mem[I_WR_ADDR0] <= I_WR_DATA[7:0];
            if (I_WR_ADDR1 < DEPTH_B) mem[I_WR_ADDR1] <= I_WR_DATA[15:8];
            if (I_WR_ADDR2 < DEPTH_B) mem[I_WR_ADDR2] <= I_WR_DATA[23:16];
            if (I_WR_ADDR3 < DEPTH_B) mem[I_WR_ADDR3] <= I_WR_DATA[31:24];
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state       <= FILL;
            word_count  <= 6'd0;
            pixel_count <= 6'd0;
            rd_data     <= 24'h000000;
            rd_valid    <= 1'b0;
        end else if (I_CLEAR) begin
            state       <= FILL;
            word_count  <= 6'd0;
            pixel_count <= 6'd0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            case (state)
                FILL: begin
                    if (wr_accept) begin
                        if (word_count == LAST_WORD) begin
                            word_count <= 6'd0;
                            state      <= DRAIN;
                        end else begin
                            word_count <= word_count + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_accept) begin
                        rd_data <= {rd_byte(I_RD_ADDRR), rd_byte(I_RD_ADDRG), rd_byte(I_RD_ADDRB)};
                        if (pixel_count == LAST_PIXEL) begin
                            pixel_count <= 6'd0;
                            state       <= FILL;
                        end else begin
                            pixel_count <= pixel_count + 6'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef CORE_PIXBUF_ERR_EN
    // Sticky until reset or clear: bit 1 = read requested in FILL, bit 0 = write requested in DRAIN.
    logic [1:0] err;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET || I_CLEAR) begin
            err <= 2'b00;
        end else begin
            if (I_RD_EN && (state == FILL))  err[1] <= 1'b1;
            if (I_WR_EN && (state == DRAIN)) err[0] <= 1'b1;
        end
    end

    assign O_ERR = err;
`else
    assign O_ERR = 2'b00;
`endif

    assign O_WR_READY    = (state == FILL);
    assign O_FULL        = (state == DRAIN);
    assign O_EMPTY       = (state == FILL) && (word_count == 6'd0);
    assign O_WORD_COUNT  = word_count;
    assign O_PIXEL_COUNT = pixel_count;
    assign O_RD_DATA     = rd_data;
    assign O_RD_VALID    = rd_valid;

endmodule

// File: tb/tb_core_pixbuf.sv
// Directed bench for core_pixbuf: linear frame fills/drains, rotated gather, range drops, errors, clear.
module tb_core_pixbuf;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET;
    logic        I_CLEAR;
    logic        I_WR_EN;
    logic [7:0]  I_WR_ADDR0, I_WR_ADDR1, I_WR_ADDR2, I_WR_ADDR3;
    logic [31:0] I_WR_DATA;
    logic        O_WR_READY;
    logic        I_RD_EN;
    logic [7:0]  I_RD_ADDRR, I_RD_ADDRG, I_RD_ADDRB;
    logic [23:0] O_RD_DATA;
    logic        O_RD_VALID;
    logic        O_FULL;
    logic        O_EMPTY;
    logic [5:0]  O_WORD_COUNT;
    logic [5:0]  O_PIXEL_COUNT;
    logic [1:0]  O_ERR;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CORE_PIXBUF_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    core_pixbuf dut (
        .I_HCLK(I_HCLK), .I_HRESET(I_HRESET), .I_CLEAR(I_CLEAR),
        .I_WR_EN(I_WR_EN), .I_WR_ADDR0(I_WR_ADDR0), .I_WR_ADDR1(I_WR_ADDR1),
        .I_WR_ADDR2(I_WR_ADDR2), .I_WR_ADDR3(I_WR_ADDR3), .I_WR_DATA(I_WR_DATA),
        .O_WR_READY(O_WR_READY), .I_RD_EN(I_RD_EN), .I_RD_ADDRR(I_RD_ADDRR),
        .I_RD_ADDRG(I_RD_ADDRG), .I_RD_ADDRB(I_RD_ADDRB), .O_RD_DATA(O_RD_DATA),
        .O_RD_VALID(O_RD_VALID), .O_FULL(O_FULL), .O_EMPTY(O_EMPTY),
        .O_WORD_COUNT(O_WORD_COUNT), .O_PIXEL_COUNT(O_PIXEL_COUNT), .O_ERR(O_ERR)
    );

    always #5 I_HCLK = ~I_HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before this are sampled there, outputs checked after it.
    task automatic step();
        @(posedge I_HCLK);
        #1;
    endtask

    task automatic wr_beat(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input logic [31:0] data);
        I_WR_EN = 1'b1;
        I_WR_ADDR0 = a0; I_WR_ADDR1 = a1; I_WR_ADDR2 = a2; I_WR_ADDR3 = a3;
        I_WR_DATA = data;
    endtask

    task automatic rd_beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        I_RD_EN = 1'b1;
        I_RD_ADDRR = r; I_RD_ADDRG = g; I_RD_ADDRB = b;
    endtask

    // Linear pattern: byte at address a holds value a.
    task automatic wr_linear(input int n);
        logic [7:0] b;
        b = 8'(4 * n);
        wr_beat(b, b + 8'd1, b + 8'd2, b + 8'd3, {b + 8'd3, b + 8'd2, b + 8'd1, b});
    endtask

    initial begin
        logic [7:0] a;
        I_HRESET = 1'b1; I_CLEAR = 1'b0; I_WR_EN = 1'b0; I_RD_EN = 1'b0;
        I_WR_ADDR0 = 8'h00; I_WR_ADDR1 = 8'h00; I_WR_ADDR2 = 8'h00; I_WR_ADDR3 = 8'h00;
        I_WR_DATA = 32'h0; I_RD_ADDRR = 8'h00; I_RD_ADDRG = 8'h00; I_RD_ADDRB = 8'h00;
        step();
        step();
        I_HRESET = 1'b0;

        chk("rst_wr_ready", 32'(O_WR_READY), 32'd1);
        chk("rst_empty", 32'(O_EMPTY), 32'd1);
        chk("rst_full", 32'(O_FULL), 32'd0);
        chk("rst_rd_valid", 32'(O_RD_VALID), 32'd0);
        chk("rst_rd_data", 32'(O_RD_DATA), 32'd0);
        chk("rst_word_count", 32'(O_WORD_COUNT), 32'd0);
        chk("rst_pixel_count", 32'(O_PIXEL_COUNT), 32'd0);
        chk("rst_err", 32'(O_ERR), 32'd0);

        // Frame 1: linear fill, linear drain.
        for (int n = 0; n < 48; n++) begin
            wr_linear(n);
            step();
            if (n == 0)  chk("f1_count_1", 32'(O_WORD_COUNT), 32'd1);
            if (n == 0)  chk("f1_not_empty", 32'(O_EMPTY), 32'd0);
            if (n == 46) chk("f1_count_47", 32'(O_WORD_COUNT), 32'd47);
            if (n == 46) chk("f1_not_full_47", 32'(O_FULL), 32'd0);
        end
        I_WR_EN = 1'b0;
        chk("f1_full", 32'(O_FULL), 32'd1);
        chk("f1_wr_ready", 32'(O_WR_READY), 32'd0);
        chk("f1_word_wrap", 32'(O_WORD_COUNT), 32'd0);
        chk("f1_empty", 32'(O_EMPTY), 32'd0);

        for (int k = 0; k < 64; k++) begin
            a = 8'(3 * k);
            rd_beat(a, a + 8'd1, a + 8'd2);
            step();
            chk("f1_rd_valid", 32'(O_RD_VALID), 32'd1);
            chk("f1_rd_data", 32'(O_RD_DATA), 32'({a, a + 8'd1, a + 8'd2}));
            chk("f1_pixel_count", 32'(O_PIXEL_COUNT), 32'((k + 1) % 64));
        end
        I_RD_EN = 1'b0;
        chk("f1_end_wr_ready", 32'(O_WR_READY), 32'd1);
        chk("f1_end_empty", 32'(O_EMPTY), 32'd1);
        chk("f1_end_full", 32'(O_FULL), 32'd0);
        step();
        chk("f1_idle_valid", 32'(O_RD_VALID), 32'd0);
        chk("f1_hold_data", 32'(O_RD_DATA), 32'h00bdbebf);

        // Frame 2: read collides with the 48th write; then overflow attempt in DRAIN.
        for (int n = 0; n < 48; n++) begin
            wr_linear(n);
            if (n == 47) rd_beat(8'h00, 8'h01, 8'h02);
            step();
        end
        I_WR_EN = 1'b0;
        I_RD_EN = 1'b0;
        chk("f2_coll_full", 32'(O_FULL), 32'd1);
        chk("f2_coll_rd_valid", 32'(O_RD_VALID), 32'd0);
        chk("f2_coll_pixels", 32'(O_PIXEL_COUNT), 32'd0);
        chk("f2_coll_err", 32'(O_ERR), 32'({ERR_ON, 1'b0}));

        wr_beat(8'h00, 8'h01, 8'h02, 8'h03, 32'hffffffff);
        step();
        I_WR_EN = 1'b0;
        chk("f2_ovf_words", 32'(O_WORD_COUNT), 32'd0);
        chk("f2_ovf_full", 32'(O_FULL), 32'd1);
        chk("f2_ovf_err", 32'(O_ERR), 32'({ERR_ON, ERR_ON}));

        // Rotated gather: column-major walk starting at 0xA8, stepping -24 per pixel.
        for (int k = 0; k < 64; k++) begin
            a = 8'(168 - 24 * (k % 8) + 3 * (k / 8));
            rd_beat(a, a + 8'd1, a + 8'd2);
            step();
            chk("f2_rot_data", 32'(O_RD_DATA), 32'({a, a + 8'd1, a + 8'd2}));
            chk("f2_rot_pixels", 32'(O_PIXEL_COUNT), 32'((k + 1) % 64));
        end
        I_RD_EN = 1'b0;
        chk("f2_end_empty", 32'(O_EMPTY), 32'd1);
        chk("f2_err_sticky", 32'(O_ERR), 32'({ERR_ON, ERR_ON}));

        I_CLEAR = 1'b1;
        step();
        I_CLEAR = 1'b0;
        chk("clr1_err", 32'(O_ERR), 32'd0);

        // Underflow: read in FILL is dropped.
        rd_beat(8'h00, 8'h01, 8'h02);
        step();
        I_RD_EN = 1'b0;
        chk("udf_rd_valid", 32'(O_RD_VALID), 32'd0);
        chk("udf_pixels", 32'(O_PIXEL_COUNT), 32'd0);
        chk("udf_empty", 32'(O_EMPTY), 32'd1);
        chk("udf_err", 32'(O_ERR), 32'({ERR_ON, 1'b0}));

        // Frame 3: abort with I_CLEAR after 20 writes.
        for (int n = 0; n < 20; n++) begin
            if (n == 0) wr_beat(8'h00, 8'h01, 8'h02, 8'hc0, 32'h99332211);
            else        wr_linear(n);
            step();
        end
        I_WR_EN = 1'b0;
        chk("f3_count_20", 32'(O_WORD_COUNT), 32'd20);
        I_CLEAR = 1'b1;
        step();
        I_CLEAR = 1'b0;
        chk("clr2_words", 32'(O_WORD_COUNT), 32'd0);
        chk("clr2_empty", 32'(O_EMPTY), 32'd1);
        chk("clr2_err", 32'(O_ERR), 32'd0);
        chk("clr2_wr_ready", 32'(O_WR_READY), 32'd1);

        // Frame 4: full frame after clear, first beat has byte 3 out of range.
        for (int n = 0; n < 48; n++) begin
            if (n == 0) wr_beat(8'h00, 8'h01, 8'h02, 8'hc0, 32'hee332211);
            else        wr_linear(n);
            step();
            if (n == 46) chk("f4_count_47", 32'(O_WORD_COUNT), 32'd47);
        end
        I_WR_EN = 1'b0;
        chk("f4_full", 32'(O_FULL), 32'd1);

        rd_beat(8'h00, 8'h01, 8'hff);
        step();
        chk("f4_rd_oob_b", 32'(O_RD_DATA), 32'h001122_00 >> 0 == 0 ? 32'd0 : 32'h00112200);
        rd_beat(8'h02, 8'h03, 8'h04);
        step();
        chk("f4_rd_mixed", 32'(O_RD_DATA), 32'h00330304);
        for (int k = 2; k < 64; k++) begin
            a = 8'(3 * k);
            rd_beat(a, a + 8'd1, a + 8'd2);
            step();
            chk("f4_rd_data", 32'(O_RD_DATA), 32'({a, a + 8'd1, a + 8'd2}));
        end
        I_RD_EN = 1'b0;
        chk("f4_end_empty", 32'(O_EMPTY), 32'd1);
        chk("f4_end_pixels", 32'(O_PIXEL_COUNT), 32'd0);
        chk("f4_end_err", 32'(O_ERR), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_pixbuf.md
# core_pixbuf

Dual-ported 192-byte pixel buffer for the rotation core, used for both the input and output buffer instances. Byte-addressed 32-bit AHB-side words are written in at four byte addresses per beat, and 24-bit RGB pixels are read out at three byte addresses per beat. A FILL/DRAIN state machine gates each side and reports buffer status to the DMA. The block consumes the address streams produced by the core pixel address generator.

## Interface
Parameters:
- DEPTH, 192: buffer size in bytes (64 pixels × 3 bytes).
- WORDS, 48: 32-bit writes per frame (DEPTH/4).
- PIXELS, 64: RGB reads per frame (DEPTH/3).

Ports:
- I_HCLK  in  1  clock; all logic on rising edge.
- I_HRESET  in  1  synchronous, active-high reset.
- I_CLEAR  in  1  synchronous abort; returns to FILL, counters cleared.
- I_WR_EN  in  1  write request.
- I_WR_ADDR0..I_WR_ADDR3  in  8 each  byte addresses for data bytes 0..3.
- I_WR_DATA  in  32  byte0=[7:0], byte1=[15:8], byte2=[23:16], byte3=[31:24].
- O_WR_READY  out  1  write side accepts this cycle.
- I_RD_EN  in  1  read request.
- I_RD_ADDRR, I_RD_ADDRG, I_RD_ADDRB  in  8 each  byte addresses of R, G, B.
- O_RD_DATA  out  24  {R[23:16], G[15:8], B[7:0]}.
- O_RD_VALID  out  1  O_RD_DATA valid this cycle.
- O_FULL  out  1  buffer in DRAIN.
- O_EMPTY  out  1  buffer in FILL with zero words written.
- O_WORD_COUNT  out  6  accepted writes this frame, 0..47.
- O_PIXEL_COUNT  out  6  accepted reads this frame, 0..63.
- O_ERR  out  2  sticky {underflow[1], overflow[0]}.

## Operation
- Storage: DEPTH×8 array. Contents are not reset.
- States: FILL (reset state) and DRAIN.
- A write is accepted when I_WR_EN=1 and the state is FILL. O_WR_READY equals (state==FILL) and is combinational from the state register.
- On an accepted write, each of the four bytes is written at its own address. A byte whose address is ≥DEPTH is dropped; the other bytes are still written.
- On an accepted write, O_WORD_COUNT increments. The 48th accepted write (count==47) sets the next state to DRAIN and the count to 0.
- A read is accepted when I_RD_EN=1 and the state is DRAIN.
- On an accepted read, O_RD_DATA is loaded from the three addresses. A component whose address is ≥DEPTH reads 8'h00.
- On an accepted read, O_PIXEL_COUNT increments. The 64th accepted read (count==63) sets the next state to FILL and the count to 0.
- Overflow: I_WR_EN=1 in DRAIN. The write is dropped and O_ERR[0] is set.
- Underflow: I_RD_EN=1 in FILL. The read is dropped and O_ERR[1] is set.
- O_ERR bits clear only on I_HRESET or I_CLEAR.
- Simultaneous I_WR_EN and I_RD_EN: only the request matching the current state is accepted. The other request is flagged as an error.
- A write and read of the same address in one cycle cannot occur, because the two sides are never active in the same state.
- Priority: I_HRESET > I_CLEAR > normal operation.
- I_CLEAR forces FILL, zeroes both counts and O_ERR, and deasserts O_RD_VALID. Memory is untouched.
- O_EMPTY = (state==FILL && O_WORD_COUNT==0).
- O_FULL = (state==DRAIN).

## Timing
- Reset values: state FILL, O_WR_READY=1, O_EMPTY=1, O_FULL=0, O_RD_VALID=0, O_RD_DATA=0, O_WORD_COUNT=0, O_PIXEL_COUNT=0, O_ERR=0.
- Write latency: data is stored at the edge that accepts the write. It is readable on the next DRAIN read.
- Read latency: 1 cycle. O_RD_VALID=1 and O_RD_DATA update in the cycle after the accepting edge. O_RD_DATA holds its value when no read is accepted.
- State changes take effect at the edge that accepts the final write or read.
  - After the 48th write, O_FULL=1 and O_WR_READY=0 in the next cycle.
  - After the 64th read, O_WR_READY=1 and O_EMPTY=1 in the next cycle. O_RD_VALID for that 64th read is still asserted in the same cycle.
- Back-to-back accepts are supported every cycle on either side, with no bubbles. A full frame takes 48 write cycles followed by 64 read cycles.
- I_CLEAR or I_HRESET mid-frame takes effect at the next edge. Any read in flight produces O_RD_VALID=0.

## Configuration
- CORE_PIXBUF_ERR_EN defined: overflow/underflow detection and the sticky O_ERR are implemented as described.
- CORE_PIXBUF_ERR_EN undefined: O_ERR is tied to 2'b00. Illegal requests are still dropped silently; accept rules and state behaviour are unchanged.

## Test plan
- Reset, then 48 writes at addresses 4n..4n+3 with data {4n+3,4n+2,4n+1,4n} -> O_FULL=1 after the 48th write; O_WORD_COUNT=0. Then 64 reads at addresses 3k,3k+1,3k+2 -> O_RD_DATA={3k,3k+1,3k+2} one cycle after each read; O_EMPTY=1 after read 64.
- Rotated read order: reads with R/G/B addresses starting at 0xA8,0xA9,0xAA, then stepping -24 per read -> each O_RD_DATA matches the stored bytes; O_PIXEL_COUNT tracks 1..63 and wraps to 0.
- Write with I_WR_ADDR3=0xC0 and the other addresses 0x00..0x02 -> bytes 0..2 stored, byte 3 dropped. Read with I_RD_ADDRB=0xFF -> B component = 0x00.
- I_WR_EN in DRAIN and I_RD_EN in FILL -> both dropped, counts unchanged, O_ERR=2'b11 with CORE_PIXBUF_ERR_EN defined and 2'b00 without it.
- I_WR_EN and I_RD_EN asserted together on the cycle of the 48th write -> write accepted, read dropped and O_ERR[1]=1, O_FULL=1 next cycle.
- I_CLEAR asserted after 20 writes -> next cycle O_WORD_COUNT=0, O_EMPTY=1, O_ERR=0; a following 48-write frame completes normally.
